// File: rtl/lsb_data_port.sv
// lsb_data_port: data-side memory responder for the load/store buffer.
// Splits B/H/W requests into byte-serial bus accesses; extends loads.
module lsb_data_port #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        need_data,
    input  logic        is_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic [2:0]  work_type,
    output logic        data_handle,
    output logic        data_ready,
    output logic [31:0] data_out,
    input  logic        mem_gnt,
    output logic        mem_req,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  type_q, type_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  c_q, c_d;
    logic [31:0] word_q, word_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic [31:0] dout_q, dout_d;

    logic        accept;
    logic        io_stall;
    logic        wr_fire;
    logic        rd_fire;
    logic        k_last;
    logic        c_last;
    logic [31:0] addr_k;
    logic [7:0]  wr_byte;
    logic [31:0] word_cap;

    // Bytes per access: B/BU = 1, H/HU = 2, W = 4.
    function automatic logic [2:0] size_of(input logic [1:0] sz);
        logic [2:0] r;
        case (sz)
            2'b00:   r = 3'd1;
            2'b01:   r = 3'd2;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sel_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] r;
        case (idx)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] put_byte(
        input logic [31:0] w,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Sign/zero extension selected by func3.
    function automatic logic [31:0] extend(
        input logic [2:0]  t,
        input logic [31:0] w
    );
        logic [31:0] r;
        case (t)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'd0, w[7:0]};
            3'b101:  r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign accept = rdy_in && (state_q == S_IDLE)
                  && need_data && !rob_clear;

    assign io_stall = (addr_q[17:16] == IO_ADDR_HI)
                    && io_buffer_full;

    assign wr_fire = rdy_in && (state_q == S_STORE)
                   && mem_gnt && !io_stall;

    assign rd_fire = rdy_in && (state_q == S_LOAD)
                   && (k_q < n_q) && mem_gnt;

    assign k_last   = (k_q == n_q - 3'd1);
    assign c_last   = (c_q == n_q - 3'd1);
    assign addr_k   = addr_q + {29'd0, k_q};
    assign wr_byte  = sel_byte(wdata_q, k_q[1:0]);
    assign word_cap = put_byte(word_q, c_q[1:0], mem_din);

    assign data_handle = accept;
    assign data_ready  = ready_q;
    assign data_out    = dout_q;
    assign mem_req     = (state_q != S_IDLE);
    assign mem_wr      = wr_fire;
    assign mem_a       = (wr_fire || rd_fire) ? addr_k : 32'd0;
    assign mem_dout    = wr_fire ? wr_byte : 8'd0;

    // Next-state logic: accept, byte-serial store, issue/capture load.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        n_d     = n_q;
        k_d     = k_q;
        c_d     = c_q;
        word_d  = word_q;
        pend_d  = pend_q;
        ready_d = 1'b0;
        dout_d  = dout_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = data_addr;
                    wdata_d = data_in;
                    type_d  = work_type;
                    n_d     = size_of(work_type[1:0]);
                    k_d     = 3'd0;
                    c_d     = 3'd0;
                    word_d  = 32'd0;
                    pend_d  = 1'b0;
                    state_d = is_write ? S_STORE : S_LOAD;
                end
            end

            // Stores already retired upstream, so a flush never stops them.
            S_STORE: begin
                if (wr_fire) begin
                    k_d = k_q + 3'd1;
                    if (k_last) begin
                        state_d = S_IDLE;
                    end
                end
            end

            // Capture trails issue by one cycle; grant loss only stalls issue.
            S_LOAD: begin
                if (rob_clear) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = rd_fire;
                    if (rd_fire) begin
                        k_d = k_q + 3'd1;
                    end
                    if (pend_q) begin
                        word_d = word_cap;
                        c_d    = c_q + 3'd1;
                        if (c_last) begin
                            ready_d = 1'b1;
                            dout_d  = extend(type_q, word_cap);
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            type_q  <= 3'd0;
            n_q     <= 3'd0;
            k_q     <= 3'd0;
            c_q     <= 3'd0;
            word_q  <= 32'd0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            n_q     <= n_d;
            k_q     <= k_d;
            c_q     <= c_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_lsb_data_port.sv
// tb_lsb_data_port: table vectors, hand sequences and random traffic
// checked against a transaction-level model of lsb_data_port.
module tb_lsb_data_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_clear;
    logic        need_data;
    logic        is_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [2:0]  work_type;
    logic        data_handle;
    logic        data_ready;
    logic [31:0] data_out;
    logic        mem_gnt;
    logic        mem_req;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    always #5 clk = ~clk;

    lsb_data_port #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .rob_clear     (rob_clear),
        .need_data     (need_data),
        .is_write      (is_write),
        .data_addr     (data_addr),
        .data_in       (data_in),
        .work_type     (work_type),
        .data_handle   (data_handle),
        .data_ready    (data_ready),
        .data_out      (data_out),
        .mem_gnt       (mem_gnt),
        .mem_req       (mem_req),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Sparse byte RAM; unwritten bytes read as an address hash.
    logic [7:0] ram [int unsigned];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous read: data for an address appears the next cycle.
    always @(posedge clk) mem_din <= ram_rd(mem_a);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        if (t[1:0] == 2'b00) return 1;
        if (t[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Load value from RAM bytes with arithmetic sign extension.
    function automatic logic [31:0] model_load(input logic [2:0] t,
                                               input logic [31:0] a);
        longint v;
        int n;
        n = nbytes(t);
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(ram_rd(a + 32'(i))) << (8 * i);
        if (!t[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Cycle (after accept) of the last store byte, or of data_ready.
    function automatic int model_lat(input logic wr, input logic [2:0] t,
                                     input logic [31:0] a,
                                     input logic [15:0] gm,
                                     input logic [15:0] fm);
        int got;
        bit g, f;
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            g = (c <= 16) ? gm[c-1] : 1'b1;
            f = (c <= 16) ? fm[c-1] : 1'b0;
            if (g && !(wr && a[17:16] == 2'b11 && f)) got++;
            if (got == nbytes(t)) return wr ? c : c + 2;
        end
        return -1;
    endfunction

    // Drive one request from a negedge and check every following cycle.
    task automatic run_txn(input logic wr, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [15:0] gm, input logic [15:0] fm,
                           input logic [15:0] cm, input logic [31:0] exp,
                           input int lat);
        int n, sent;
        bit done, g, fire, io;
        logic [31:0] sh;
        n = nbytes(t);
        sent = 0;
        done = 0;
        io = (a[17:16] == 2'b11);
        rdy = 1'b1;
        rob_clear = 1'b0;
        need_data = 1'b1;
        is_write = wr;
        data_addr = a;
        data_in = d;
        work_type = t;
        mem_gnt = 1'b1;
        io_buffer_full = 1'b0;
        #1;
        chk("accept", data_handle, 1);
        chk("idle_req", mem_req, 0);
        chk("idle_wr", mem_wr, 0);
        @(negedge clk);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            g = (cyc <= 16) ? gm[cyc-1] : 1'b1;
            mem_gnt = g;
            io_buffer_full = (cyc <= 16) ? fm[cyc-1] : 1'b0;
            rob_clear = (cyc <= 16) ? cm[cyc-1] : 1'b0;
            need_data = (cyc < lat);
            data_addr = a ^ 32'h4;
            #1;
            fire = (sent < n) && g && !(wr && io && io_buffer_full);
            sh = d >> (8 * sent);
            chk("busy_handle", data_handle, 0);
            chk("req", mem_req, wr ? (cyc <= lat) : (cyc < lat));
            chk("wr", mem_wr, wr && fire);
            chk("addr", mem_a, fire ? a + 32'(sent) : 32'h0);
            chk("dout", mem_dout, (wr && fire) ? {24'h0, sh[7:0]} : 32'h0);
            chk("ready", data_ready, !wr && cyc == lat);
            if (!wr && cyc == lat) begin
                chk("data", data_out, exp);
                done = 1;
            end
            if (mem_wr) ram[mem_a] = mem_dout;
            if (fire) sent++;
            if (wr && sent == n) begin
                chk("st_lat", cyc, lat);
                done = 1;
            end
            @(negedge clk);
        end
        rob_clear = 1'b0;
        need_data = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no completion want cycle %0d", lat);
        end
        #1;
        chk("post_ready", data_ready, 0);
        chk("post_req", mem_req, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic        pre;
        logic [31:0] r;
        logic [15:0] gm;
        logic [15:0] fm;
        logic [15:0] cm;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic pre, input logic [31:0] r,
                       input logic [15:0] gm, input logic [15:0] fm,
                       input logic [15:0] cm, input logic [31:0] exp,
                       input int lat);
        vec_t v;
        v.wr = wr; v.t = t; v.a = a; v.d = d; v.pre = pre; v.r = r;
        v.gm = gm; v.fm = fm; v.cm = cm; v.exp = exp; v.lat = lat;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic        wr;
        logic [2:0]  t;
        logic [31:0] a, d;
        logic [15:0] gm, fm, cm;
        int          sel;

        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; need_data = 1'b0;
        is_write = 1'b0; data_addr = 32'h0; data_in = 32'h0;
        work_type = 3'b000; mem_gnt = 1'b0; io_buffer_full = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_ready", data_ready, 0);
        chk("rst_out", data_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_dout", mem_dout, 0);
        rst = 1'b0;
        @(negedge clk);

        //   wr  t       addr          data          pre r             gm        fm       cm       exp           lat
        add(1, 3'b010, 32'h100,      32'hDEADBEEF, 0, 32'h0,         16'hFFFF, 16'h0, 16'h0, 32'h0,        4);
        add(0, 3'b000, 32'h20,       32'h0,        1, 32'h00000080,  16'hFFFF, 16'h0, 16'h0, 32'hFFFFFF80, 3);
        add(0, 3'b100, 32'h20,       32'h0,        0, 32'h0,         16'hFFFF, 16'h0, 16'h0, 32'h00000080, 3);
        add(0, 3'b001, 32'h40,       32'h0,        1, 32'h00009234,  16'hFFFF, 16'h0, 16'h0, 32'hFFFF9234, 4);
        add(0, 3'b101, 32'h40,       32'h0,        0, 32'h0,         16'hFFFF, 16'h0, 16'h0, 32'h00009234, 4);
        add(0, 3'b010, 32'h10,       32'h0,        1, 32'h44332211,  16'hFFF9, 16'h0, 16'h0, 32'h44332211, 8);
        add(0, 3'b010, 32'h100,      32'h0,        0, 32'h0,         16'hFFFF, 16'h0, 16'h0, 32'hDEADBEEF, 6);
        add(1, 3'b000, 32'h30000,    32'h1234565A, 0, 32'h0,         16'hFFFF, 16'h7,  16'h2, 32'h0,        4);
        add(0, 3'b100, 32'h30000,    32'h0,        0, 32'h0,         16'hFFFF, 16'h0, 16'h0, 32'h0000005A, 3);
        add(0, 3'b010, 32'hFFFFFFFE, 32'h0,        1, 32'hC0FFEE12,  16'hFFFF, 16'h0, 16'h0, 32'hC0FFEE12, 6);
        add(0, 3'b001, 32'h201,      32'h0,        1, 32'h0000F00D,  16'hFFFF, 16'h0, 16'h0, 32'hFFFFF00D, 4);

        foreach (tbl[i]) begin
            if (tbl[i].pre)
                for (int j = 0; j < 4; j++)
                    ram[tbl[i].a + 32'(j)] = 8'(tbl[i].r >> (8 * j));
            run_txn(tbl[i].wr, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].gm,
                    tbl[i].fm, tbl[i].cm, tbl[i].exp, tbl[i].lat);
        end

        // LW flushed after two bytes; a new LB is taken the next cycle.
        rdy = 1'b1; need_data = 1'b1; is_write = 1'b0;
        data_addr = 32'h10; work_type = 3'b010; mem_gnt = 1'b1;
        #1;
        chk("clr_accept", data_handle, 1);
        @(negedge clk);
        need_data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rob_clear = 1'b1; need_data = 1'b1;
        data_addr = 32'h20; work_type = 3'b000;
        #1;
        chk("clr_no_accept", data_handle, 0);
        chk("clr_ready", data_ready, 0);
        @(negedge clk);
        run_txn(0, 3'b000, 32'h20, 32'h0, 16'hFFFF, 16'h0, 16'h0,
                32'hFFFFFF80, 3);

        // rdy_in low blocks acceptance.
        rdy = 1'b0; need_data = 1'b1; is_write = 1'b1;
        data_addr = 32'h300; work_type = 3'b010; mem_gnt = 1'b1;
        #1;
        chk("rdy_handle", data_handle, 0);
        chk("rdy_wr", mem_wr, 0);
        @(negedge clk);
        run_txn(1, 3'b001, 32'h300, 32'h0000A55A, 16'hFFFF, 16'h0,
                16'h0, 32'h0, 2);

        // Reset in the middle of a load: no completion pulse.
        need_data = 1'b1; is_write = 1'b0;
        data_addr = 32'h10; work_type = 3'b010; mem_gnt = 1'b1;
        #1;
        chk("rst_mid_accept", data_handle, 1);
        @(negedge clk);
        need_data = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_a", mem_a, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rst_mid_ready", data_ready, 0);
            @(negedge clk);
        end

        // Random traffic against the transaction model.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            if (wr) begin
                t = 3'($urandom_range(0, 2));
            end else begin
                sel = $urandom_range(0, 4);
                t = (sel < 3) ? 3'(sel) : 3'(sel + 1);
            end
            case ($urandom_range(0, 2))
                0: a = 32'($urandom_range(0, 255));
                1: a = 32'h0003_0000 + 32'($urandom_range(0, 15));
                default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            d = $urandom;
            gm = 16'($urandom);
            fm = 16'($urandom);
            cm = wr ? 16'($urandom) : 16'h0;
            run_txn(wr, t, a, d, gm, fm, cm,
                    wr ? 32'h0 : model_load(t, a),
                    model_lat(wr, t, a, gm, fm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
